shift_seq_unit: RTL and testbench
=================================

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width; only powers of two, 8..64, are legal.
REQ-002 Parameter SHW, default 5, SHALL set the shift-amount width and SHALL equal log2(WIDTH).
REQ-003 Parameter CONST_AMT, default 16, SHALL set the constant amount channel; legal range 0..WIDTH-1.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port reset_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-006 Port start, input, 1, SHALL be the request to begin an operation.
REQ-007 Port op, input, 2, SHALL select the operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 Port data_in, input, WIDTH, SHALL carry the operand to shift.
REQ-009 Port amt_sel, input, 2, SHALL select the amount source: 00 amt_reg[SHW-1:0], 01 amt_imm, 10 CONST_AMT, 11 amt_alt.
REQ-010 Ports amt_reg (WIDTH), amt_imm (SHW) and amt_alt (SHW), all inputs, SHALL carry the candidate shift amounts.
REQ-011 Port result, output, WIDTH, SHALL carry the working and final value.
REQ-012 Port busy, output, 1, SHALL be high while an operation is in progress.
REQ-013 Port done, output, 1, SHALL be a one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have three states, IDLE, SHIFT and DONE, and SHALL be encoded as IDLE after reset.
REQ-015 In IDLE, start=1 at edge t0 SHALL capture the following:
- data_in into result;
- the selected amount into a SHW-bit counter cnt;
- op into an internal register.
REQ-016 At edge t0 the FSM SHALL move to SHIFT if the captured amount is nonzero, and to DONE otherwise.
REQ-017 In SHIFT, each edge SHALL shift result by exactly one bit according to the latched op and SHALL decrement cnt.
- SLL fills with 0.
- SRL fills with 0.
- SRA replicates the MSB.
- ROR moves bit 0 into the MSB.
REQ-018 When cnt is 1 before an edge in SHIFT, that edge SHALL perform the final shift and move the FSM to DONE.
REQ-019 done SHALL be high only in DONE, i.e. during the cycle after edge t0+amount; latency is amount+1 cycles (amount 0 -> 1 cycle).
REQ-020 From DONE the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-021 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-022 start SHALL be ignored in SHIFT and DONE; it SHALL NOT queue, and the in-flight operation SHALL NOT be disturbed.
REQ-023 Input changes after t0 (op, data_in, amt_*, amt_sel) SHALL NOT affect the in-flight operation.
REQ-024 result SHALL hold its final value in DONE and afterwards in IDLE until the next accepted start.
REQ-025 Amounts SHALL be taken modulo WIDTH by using only the low SHW bits; the maximum is WIDTH-1 shifts.

Reset
REQ-026 reset_n=0 SHALL asynchronously force the following, including mid-operation:
- FSM to IDLE;
- result to 0;
- cnt to 0;
- busy to 0;
- done to 0.
REQ-027 After reset_n is released, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SHIFT_SEQ_ROTATE_EN, when defined, SHALL enable ROR for op=11 as specified in REQ-017.
REQ-029 Without SHIFT_SEQ_ROTATE_EN, op=11 SHALL be a passthrough: the amount is forced to 0, done follows after 1 cycle and result equals data_in.

Verification (WIDTH=32, CONST_AMT=16)
REQ-030 The bench SHALL cover each of the following scenarios:
- SLL, data_in=0x00000001, amt_sel=01, amt_imm=4 -> busy for 5 cycles, done pulse after edge t0+4, result=0x00000010.
- SRA, data_in=0x80000000, amt_sel=10 -> done after edge t0+16, result=0xFFFF8000.
- SRL, amt_sel=00, amt_reg=0xFFFFFFE3 (low 5 bits = 3), data_in=0xF0000000 -> result=0x1E000000.
- amt_imm=0 -> done in the cycle after t0, result=data_in.
- start reasserted in SHIFT -> ignored, original result unchanged; then reset_n=0 mid-SHIFT -> result=0, busy=0 and done=0 immediately, without waiting for a clock edge.
- op=11, data_in=0x00000001, amt_imm=1 -> 0x80000000 with SHIFT_SEQ_ROTATE_EN, 0x00000001 after 1 cycle without it.

Source files
------------

// File: rtl/shift_seq_unit.sv
// -----------------------------------------------------------------------------
// shift_seq_unit
//
// Purpose:
//   Sequential bit-serial shifter. A start request latches an operand, a
//   shift amount and an operation. The unit then shifts the operand one bit
//   per clock until the amount is used up. done pulses for one cycle when
//   the operation completes. result holds the final value until the next
//   accepted start.
//
// Parameters:
//   WIDTH     - data width (power of two, 8..64)
//   SHW       - shift-amount width, equal to log2(WIDTH)
//   CONST_AMT - amount used when amt_sel = 2'b10 (0..WIDTH-1)
//
// Ports:
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   begin an operation (only accepted in IDLE)
//   op       in   2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROR
//   data_in  in   operand to shift
//   amt_sel  in   amount source: 00 amt_reg[SHW-1:0], 01 amt_imm,
//                 10 CONST_AMT, 11 amt_alt
//   amt_reg  in   WIDTH-bit amount candidate (only the low SHW bits are used)
//   amt_imm  in   SHW-bit amount candidate
//   amt_alt  in   SHW-bit amount candidate
//   result   out  working value while shifting, final value afterwards
//   busy     out  high in SHIFT and DONE
//   done     out  one-cycle completion pulse (high in DONE)
//
// Configuration macro:
//   SHIFT_SEQ_ROTATE_EN - when defined, op=11 rotates right by the amount.
//                         When undefined, op=11 is a passthrough: the amount
//                         is forced to 0 and result equals data_in one cycle
//                         later.
// -----------------------------------------------------------------------------
module shift_seq_unit #(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter int CONST_AMT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       amt_sel,
  input  logic [WIDTH-1:0] amt_reg,
  input  logic [SHW-1:0]   amt_imm,
  input  logic [SHW-1:0]   amt_alt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_IMM   = 2'b01;
  localparam logic [1:0] SEL_CONST = 2'b10;

  localparam logic [SHW-1:0] CONST_AMT_C = SHW'(CONST_AMT);
  localparam logic [SHW-1:0] ONE_C       = SHW'(1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q,    cnt_d;
  logic [1:0]       op_q,     op_d;

  logic [SHW-1:0]   amt_sel_val;
  logic [SHW-1:0]   amt_eff;
  logic [WIDTH-1:0] shifted;

  // Only the low SHW bits of amt_reg take part (amount modulo WIDTH).
  logic unused_amt_hi;
  assign unused_amt_hi = ^amt_reg[WIDTH-1:SHW];

  // Amount source selection.
  always_comb begin
    amt_sel_val = amt_alt;
    case (amt_sel)
      SEL_REG:   amt_sel_val = amt_reg[SHW-1:0];
      SEL_IMM:   amt_sel_val = amt_imm;
      SEL_CONST: amt_sel_val = CONST_AMT_C;
      default:   amt_sel_val = amt_alt;
    endcase
  end

  // Without rotate support, op=11 degenerates to a zero-length operation so
  // it completes in one cycle with result equal to the operand.
  always_comb begin
    amt_eff = amt_sel_val;
`ifdef SHIFT_SEQ_ROTATE_EN
    amt_eff = amt_sel_val;
`else
    if (op == OP_ROR) begin
      amt_eff = '0;
    end
`endif
  end

  // One-bit step of the latched operation.
  always_comb begin
    shifted = result_q;
    case (op_q)
      OP_SLL:  shifted = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  shifted = {result_q[0], result_q[WIDTH-1:1]};
`else
      // Never reaches SHIFT with op=11 in this build; hold the value.
      OP_ROR:  shifted = result_q;
`endif
      default: shifted = result_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          result_d = data_in;
          cnt_d    = amt_eff;
          op_d     = op;
          state_d  = (amt_eff != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - ONE_C;
        // cnt==1 means this edge performs the last shift.
        if (cnt_q == ONE_C) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= OP_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  // Status decoded straight from the state register so that reset clears
  // busy and done immediately.
  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_unit
//
// Purpose:
//   Directed self-checking bench for shift_seq_unit (WIDTH=32, CONST_AMT=16).
//   Each transaction gets a one-line report; a single summary line ends the run.
//   Expected ROR behaviour follows SHIFT_SEQ_ROTATE_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_shift_seq_unit;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       amt_sel;
  logic [WIDTH-1:0] amt_reg;
  logic [SHW-1:0]   amt_imm;
  logic [SHW-1:0]   amt_alt;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  shift_seq_unit #(
    .WIDTH     (WIDTH),
    .SHW       (SHW),
    .CONST_AMT (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .amt_sel (amt_sel),
    .amt_reg (amt_reg),
    .amt_imm (amt_imm),
    .amt_alt (amt_alt),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scramble all operand inputs; the in-flight operation must not see them.
  task automatic scramble();
    op      = 2'b01;
    data_in = 32'hDEAD_BEEF;
    amt_sel = 2'b00;
    amt_reg = 32'h0000_0007;
    amt_imm = 5'd9;
    amt_alt = 5'd2;
  endtask

  // Issue one operation from IDLE and follow it to completion.
  task automatic run_op(input string tag, input logic [1:0] op_i,
                        input logic [31:0] data_i, input logic [1:0] sel_i,
                        input logic [31:0] reg_i, input logic [4:0] imm_i,
                        input logic [4:0] alt_i, input int exp_amt,
                        input logic [31:0] exp_res);
    int n;
    op      = op_i;
    data_in = data_i;
    amt_sel = sel_i;
    amt_reg = reg_i;
    amt_imm = imm_i;
    amt_alt = alt_i;
    start   = 1'b1;
    tick();                         // edge t0
    start = 1'b0;
    scramble();
    n = 0;
    while (!done && n < 100) begin
      check_val({tag, "_busy_shift"}, 32'(busy), 32'd1);
      tick();
      n++;
    end
    check_val({tag, "_latency"}, n, exp_amt);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_busy_done"}, 32'(busy), 32'd1);
    check_val({tag, "_result"}, result, exp_res);
    tick();
    check_val({tag, "_done_low"}, 32'(done), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
    check_val({tag, "_hold"}, result, exp_res);
    $display("txn %s op=%0d amt=%0d cycles=%0d result=0x%08h", tag, op_i,
             exp_amt, n, result);
  endtask

  logic [31:0] ror1_exp;
  logic [31:0] ror4_exp;
  int          ror1_amt;
  int          ror4_amt;

  initial begin
`ifdef SHIFT_SEQ_ROTATE_EN
    ror1_exp = 32'h8000_0000;  ror1_amt = 1;
    ror4_exp = 32'h8123_4567;  ror4_amt = 4;
`else
    ror1_exp = 32'h0000_0001;  ror1_amt = 0;
    ror4_exp = 32'h1234_5678;  ror4_amt = 0;
`endif
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    data_in = '0;
    amt_sel = 2'b00;
    amt_reg = '0;
    amt_imm = '0;
    amt_alt = '0;
    tick();
    tick();
    check_val("rst_result", result, 32'h0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    $display("txn reset result=0x%08h busy=%0b done=%0b", result, busy, done);

    run_op("sll_imm4",  2'b00, 32'h0000_0001, 2'b01, 32'h0, 5'd4,  5'd0,  4,  32'h0000_0010);
    run_op("sra_const", 2'b10, 32'h8000_0000, 2'b10, 32'h0, 5'd0,  5'd0,  16, 32'hFFFF_8000);
    run_op("srl_reg",   2'b01, 32'hF000_0000, 2'b00, 32'hFFFF_FFE3, 5'd0, 5'd0, 3, 32'h1E00_0000);
    run_op("amt_zero",  2'b00, 32'hA5A5_A5A5, 2'b01, 32'h0, 5'd0,  5'd0,  0,  32'hA5A5_A5A5);
    run_op("sll_max",   2'b00, 32'hFFFF_FFFF, 2'b11, 32'h0, 5'd0,  5'd31, 31, 32'h8000_0000);
    run_op("ror_imm1",  2'b11, 32'h0000_0001, 2'b01, 32'h0, 5'd1,  5'd0,  ror1_amt, ror1_exp);
    run_op("ror_alt4",  2'b11, 32'h1234_5678, 2'b11, 32'h0, 5'd0,  5'd4,  ror4_amt, ror4_exp);

    // start reasserted mid-SHIFT must be ignored.
    op = 2'b00; data_in = 32'h0000_0001; amt_sel = 2'b01; amt_imm = 5'd8;
    start = 1'b1;
    tick();                         // t0
    start = 1'b0;
    tick();
    op = 2'b01; data_in = 32'h0000_FFFF; amt_imm = 5'd1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check_val("ign_mid_result", result, 32'h0000_0008);
    check_val("ign_mid_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5 && !done; i++) tick();
    check_val("ign_done", 32'(done), 32'd1);
    check_val("ign_result", result, 32'h0000_0100);
    tick();
    check_val("ign_idle", 32'(busy), 32'd0);
    $display("txn start_ignored result=0x%08h", result);

    // Asynchronous reset in the middle of a shift.
    run_op("pre_rst", 2'b00, 32'h0000_0001, 2'b01, 32'h0, 5'd2, 5'd0, 2, 32'h0000_0004);
    op = 2'b00; data_in = 32'h0000_0001; amt_sel = 2'b01; amt_imm = 5'd10;
    start = 1'b1;
    tick();                         // t0
    start = 1'b0;
    tick();
    tick();
    tick();
    check_val("mid_result", result, 32'h0000_0008);
    reset_n = 1'b0;
    #1;                             // no clock edge before this sample
    check_val("arst_result", result, 32'h0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_done", 32'(done), 32'd0);
    $display("txn async_reset result=0x%08h busy=%0b done=%0b", result, busy, done);
    tick();
    reset_n = 1'b1;
    #2;
    run_op("post_rst", 2'b00, 32'h0000_0003, 2'b01, 32'h0, 5'd2, 5'd0, 2, 32'h0000_000C);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
